wash_cycle_ctrl: RTL

WASH_CYCLE_CTRL -- requirements
Module: wash_cycle_ctrl

---
 rtl/wash_pkg.sv | 26 ++
 rtl/wash_timer.sv | 27 ++
 rtl/wash_cycle_ctrl.sv | 139 +++++++++++++
 3 files changed

// File: rtl/wash_pkg.sv
// Shared types for the wash cycle controller: FSM states and motor drive codes.
package wash_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RUN_CW  = 3'd1,
        STOP_A  = 3'd2,
        RUN_CCW = 3'd3,
        STOP_B  = 3'd4
    } wash_state_t;

    typedef enum logic [1:0] {
        MOTOR_STOP = 2'd0,
        MOTOR_CW   = 2'd1,
        MOTOR_CCW  = 2'd2
    } motor_t;

    function automatic motor_t motor_of(input wash_state_t s);
        case (s)
            RUN_CW:  return MOTOR_CW;
            RUN_CCW: return MOTOR_CCW;
            default: return MOTOR_STOP;
        endcase
    endfunction

endpackage

// File: rtl/wash_timer.sv
// Phase timer: counts 0..tc while enabled, wraps to 0 after tc, clears on demand.
module wash_timer #(
    parameter int CNTW = 6
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clr,
    input  logic            en,
    input  logic [CNTW-1:0] tc,
    output logic            at_tc
);

    logic [CNTW-1:0] cnt_q;

    assign at_tc = (cnt_q == tc);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (en) begin
            cnt_q <= at_tc ? '0 : cnt_q + CNTW'(1);
        end
    end

endmodule

// File: rtl/wash_cycle_ctrl.sv
// Washing-machine drum sequencer: NREP rounds of CW / pause / CCW / pause,
// with hold (freeze in place) and abort, all outputs registered.
module wash_cycle_ctrl
    import wash_pkg::*;
#(
    parameter int CNTW    = 6,
    parameter int CW_T    = 32,
    parameter int CCW_T   = 32,
    parameter int PAUSE_T = 16,
    parameter int NREP    = 3,
    parameter int RW      = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          hold,
    input  logic          abort,
    output logic [1:0]    motor,
    output logic          busy,
    output logic          done,
    output logic [RW-1:0] round
);

    if (CW_T < 1 || CW_T > (1 << CNTW) ||
        CCW_T < 1 || CCW_T > (1 << CNTW) ||
        PAUSE_T < 1 || PAUSE_T > (1 << CNTW)) begin : g_bad_phase_len
        $error("wash_cycle_ctrl: phase lengths must lie in 1..2**CNTW");
    end

    if (NREP < 1 || NREP > (1 << RW)) begin : g_bad_nrep
        $error("wash_cycle_ctrl: NREP must lie in 1..2**RW");
    end

    localparam logic [CNTW-1:0] CW_TC    = CNTW'(CW_T - 1);
    localparam logic [CNTW-1:0] CCW_TC   = CNTW'(CCW_T - 1);
    localparam logic [CNTW-1:0] PAUSE_TC = CNTW'(PAUSE_T - 1);
    localparam logic [RW:0]     NREP_V   = (RW + 1)'(NREP);

    wash_state_t   state_q, state_d;
    logic [RW-1:0] round_q, round_d;
    motor_t        motor_q, motor_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    logic            tmr_clr;
    logic            tmr_en;
    logic [CNTW-1:0] tmr_tc;
    logic            tmr_at_tc;

    wash_timer #(
        .CNTW (CNTW)
    ) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (tmr_clr),
        .en    (tmr_en),
        .tc    (tmr_tc),
        .at_tc (tmr_at_tc)
    );

    always_comb begin
        state_d = state_q;
        round_d = round_q;
        done_d  = 1'b0;
        tmr_clr = 1'b0;
        tmr_en  = 1'b0;

        case (state_q)
            RUN_CW:          tmr_tc = CW_TC;
            RUN_CCW:         tmr_tc = CCW_TC;
            STOP_A, STOP_B:  tmr_tc = PAUSE_TC;
            default:         tmr_tc = '0;
        endcase

        // Priority: abort, then hold, then phase expiry; hold is meaningless in IDLE.
        if (state_q == IDLE) begin
            tmr_clr = 1'b1;
            round_d = '0;
            if (start && !abort) begin
                state_d = RUN_CW;
            end
        end else if (abort) begin
            state_d = IDLE;
            round_d = '0;
            tmr_clr = 1'b1;
        end else if (!hold) begin
            tmr_en = 1'b1;
            if (tmr_at_tc) begin
                case (state_q)
                    RUN_CW:  state_d = STOP_A;
                    STOP_A:  state_d = RUN_CCW;
                    RUN_CCW: state_d = STOP_B;
                    STOP_B: begin
                        if (({1'b0, round_q} + (RW + 1)'(1)) < NREP_V) begin
                            state_d = RUN_CW;
                            round_d = round_q + RW'(1);
                        end else begin
                            state_d = IDLE;
                            round_d = '0;
                            done_d  = 1'b1;
                        end
                    end
                    default: state_d = IDLE;
                endcase
            end
        end

        // A held wash keeps its state but the drum must stand still.
        if (state_q != IDLE && !abort && hold) begin
            motor_d = MOTOR_STOP;
        end else begin
            motor_d = motor_of(state_d);
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            round_q <= '0;
            motor_q <= MOTOR_STOP;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            round_q <= round_d;
            motor_q <= motor_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign motor = motor_q;
    assign busy  = busy_q;
    assign done  = done_q;
    assign round = round_q;

endmodule
